// File: rtl/control_pkg.sv
// Shared definitions for the commit sequencer.
// Holds instruction IDs, op classifiers and the FSM state encoding.
package control_pkg;

    localparam int unsigned ID_MEM_LO    = 39;
    localparam int unsigned ID_MEM_HI    = 55;
    localparam int unsigned ID_MEM_A     = 67;
    localparam int unsigned ID_MEM_B     = 68;
    localparam int unsigned ID_OUTPUT    = 69;
    localparam int unsigned ID_PAUSE     = 70;
    localparam int unsigned ID_INPUT     = 71;
    localparam int unsigned ID_HALT      = 75;
    localparam int unsigned ID_BIOS_EXIT = 78;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_IO_WAIT  = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

    function automatic logic is_mem_op(input logic [31:0] id);
        return ((id >= ID_MEM_LO) && (id <= ID_MEM_HI))
            || (id == ID_MEM_A) || (id == ID_MEM_B);
    endfunction

    function automatic logic is_io_op(input logic [31:0] id);
        return (id == ID_OUTPUT) || (id == ID_PAUSE) || (id == ID_INPUT);
    endfunction

    function automatic logic is_halt_op(input logic [31:0] id);
        return id == ID_HALT;
    endfunction

    // Encoding reported on waiting_io: 1 OUTPUT, 2 INPUT, 3 PAUSE.
    function automatic logic [1:0] io_code(input logic [31:0] id);
        logic [1:0] code;
        code = 2'd0;
        if (id == ID_OUTPUT) code = 2'd1;
        if (id == ID_INPUT)  code = 2'd2;
        if (id == ID_PAUSE)  code = 2'd3;
        return code;
    endfunction

endpackage

// File: rtl/button_edge_sync.sv
// Synchronises an asynchronous button and flags its 0->1 transitions.
module button_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], async_in};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle commit sequencer: decides the cycle in which each decoded
// instruction commits, covering memory waits, I/O handshakes and HALT.
module control_sequencer
    import control_pkg::*;
#(
    parameter int ID_WIDTH        = 7,
    parameter int MEM_WAIT_CYCLES = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ID_WIDTH-1:0]  id,
    input  logic                 id_valid,
    input  logic                 confirmation,
    input  logic                 continue_button,
    output logic                 enable,
    output logic                 stall,
    output logic [1:0]           waiting_io,
    output logic                 halted,
    output logic                 bios_exit,
    output logic [CNT_WIDTH-1:0] retired_count
);

    state_e                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic [ID_WIDTH-1:0]   op_q, op_d;
    logic [CNT_WIDTH-1:0]  retired_q, retired_d;

    logic [31:0] id_ext;
    logic [31:0] op_ext;
    logic        conf_rise;
    logic        cont_rise;
    logic        io_rise;
    logic        en_c;
    logic        bios_c;

    assign id_ext = 32'(id);
    assign op_ext = 32'(op_q);

    button_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_conf_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (confirmation),
        .rise     (conf_rise)
    );

    button_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cont_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (continue_button),
        .rise     (cont_rise)
    );

    assign io_rise = (op_ext == ID_PAUSE) ? cont_rise : conf_rise;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        op_d    = op_q;
        en_c    = 1'b0;
        bios_c  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (id_valid) begin
                    if (is_halt_op(id_ext)) begin
                        state_d = ST_HALTED;
                    end else if (is_io_op(id_ext)) begin
                        op_d    = id;
                        state_d = ST_IO_WAIT;
                    end else if (is_mem_op(id_ext) && (MEM_WAIT_CYCLES != 0)) begin
                        wait_d  = 4'(MEM_WAIT_CYCLES);
                        state_d = ST_MEM_WAIT;
                    end else begin
                        en_c   = 1'b1;
                        bios_c = (id_ext == ID_BIOS_EXIT);
                    end
                end
            end
            ST_MEM_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) begin
                    en_c    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_IO_WAIT: begin
                if (io_rise) begin
                    en_c    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Held-low reset forces the commit outputs quiet even while id is driven.
    assign enable    = en_c & reset;
    assign bios_exit = bios_c & reset;
    assign retired_d = enable ? (retired_q + CNT_WIDTH'(1)) : retired_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            wait_q    <= 4'd0;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    assign stall         = (state_q != ST_RUN);
    assign halted        = (state_q == ST_HALTED);
    assign waiting_io    = (state_q == ST_IO_WAIT) ? io_code(op_ext) : 2'd0;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer
// (MEM_WAIT_CYCLES=2, SYNC_STAGES=2, CNT_WIDTH=4).
module tb_control_sequencer;

    logic       clock;
    logic       reset;
    logic [6:0] id;
    logic       id_valid;
    logic       confirmation;
    logic       continue_button;
    logic       enable;
    logic       stall;
    logic [1:0] waiting_io;
    logic       halted;
    logic       bios_exit;
    logic [3:0] retired_count;

    int checks;
    int errors;
    int n;

    control_sequencer #(
        .ID_WIDTH        (7),
        .MEM_WAIT_CYCLES (2),
        .SYNC_STAGES     (2),
        .CNT_WIDTH       (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .id              (id),
        .id_valid        (id_valid),
        .confirmation    (confirmation),
        .continue_button (continue_button),
        .enable          (enable),
        .stall           (stall),
        .waiting_io      (waiting_io),
        .halted          (halted),
        .bios_exit       (bios_exit),
        .retired_count   (retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b0;
        id              = 7'd4;
        id_valid        = 1'b1;
        confirmation    = 1'b0;
        continue_button = 1'b0;

        // Reset held with a valid SIMPLE id on the bus
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("rst_enable", 32'(enable), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_wio", 32'(waiting_io), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_bios", 32'(bios_exit), 0);
        chk("rst_count", 32'(retired_count), 0);

        // Three SIMPLE commits
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id = 7'd4;
            id_valid = 1'b1;
            #1;
            chk("simple_en", 32'(enable), 1);
            chk("simple_stall", 32'(stall), 0);
            @(negedge clock);
        end
        chk("simple_count", 32'(retired_count), 3);

        // MEM op, two wait states; a HALT id during stall is ignored
        id = 7'd44;
        id_valid = 1'b1;
        #1;
        chk("mem_c0_en", 32'(enable), 0);
        chk("mem_c0_stall", 32'(stall), 0);
        @(negedge clock);
        id = 7'd75;
        #1;
        chk("mem_c1_en", 32'(enable), 0);
        chk("mem_c1_stall", 32'(stall), 1);
        @(negedge clock);
        #1;
        chk("mem_c2_en", 32'(enable), 1);
        chk("mem_c2_stall", 32'(stall), 1);
        @(negedge clock);
        id_valid = 1'b0;
        #1;
        chk("mem_after_stall", 32'(stall), 0);
        chk("mem_after_halt", 32'(halted), 0);
        chk("mem_count", 32'(retired_count), 4);

        // OUTPUT with confirmation already high at entry
        confirmation = 1'b1;
        repeat (4) @(negedge clock);
        id = 7'd69;
        id_valid = 1'b1;
        #1;
        chk("out_entry_en", 32'(enable), 0);
        @(negedge clock);
        id_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (enable) n++;
            chk("out_held_wio", 32'(waiting_io), 1);
            @(negedge clock);
        end
        chk("out_held_nocommit", 32'(n), 0);
        confirmation = 1'b0;
        repeat (4) @(negedge clock);
        confirmation = 1'b1;
        #1;
        chk("out_edge_k0", 32'(enable), 0);
        @(negedge clock);
        #1;
        chk("out_edge_k1", 32'(enable), 0);
        @(negedge clock);
        #1;
        chk("out_edge_k2", 32'(enable), 1);
        chk("out_edge_wio", 32'(waiting_io), 1);
        @(negedge clock);
        #1;
        chk("out_done_en", 32'(enable), 0);
        chk("out_done_stall", 32'(stall), 0);
        chk("out_done_wio", 32'(waiting_io), 0);
        chk("out_count", 32'(retired_count), 5);
        confirmation = 1'b0;

        // PAUSE ignores confirmation, commits on continue_button
        @(negedge clock);
        id = 7'd70;
        id_valid = 1'b1;
        #1;
        chk("pause_entry_en", 32'(enable), 0);
        @(negedge clock);
        id_valid = 1'b0;
        confirmation = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) confirmation = 1'b0;
            #1;
            if (enable) n++;
            @(negedge clock);
        end
        chk("pause_conf_ignored", 32'(n), 0);
        chk("pause_wio", 32'(waiting_io), 3);
        continue_button = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (enable) n++;
            @(negedge clock);
        end
        chk("pause_once", 32'(n), 1);
        chk("pause_stall", 32'(stall), 0);
        chk("pause_count", 32'(retired_count), 6);
        continue_button = 1'b0;

        // BIOS exit pulse then HALT
        id = 7'd78;
        id_valid = 1'b1;
        #1;
        chk("bios_en", 32'(enable), 1);
        chk("bios_pulse", 32'(bios_exit), 1);
        @(negedge clock);
        id = 7'd75;
        #1;
        chk("halt_entry_en", 32'(enable), 0);
        chk("halt_entry_bios", 32'(bios_exit), 0);
        chk("bios_count", 32'(retired_count), 7);
        @(negedge clock);
        for (int i = 0; i < 20; i++) begin
            id = 7'(i * 5);
            id_valid = 1'b1;
            confirmation = i[0];
            continue_button = i[1];
            #1;
            chk("halt_halted", 32'(halted), 1);
            chk("halt_en", 32'(enable), 0);
            @(negedge clock);
        end
        chk("halt_count", 32'(retired_count), 7);
        confirmation = 1'b0;
        continue_button = 1'b0;
        id_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("halt_rst_halted", 32'(halted), 0);
        chk("halt_rst_stall", 32'(stall), 0);
        chk("halt_rst_count", 32'(retired_count), 0);
        @(negedge clock);
        reset = 1'b1;

        // 17 SIMPLE commits wrap a 4-bit counter to 1
        id = 7'd12;
        id_valid = 1'b1;
        repeat (17) @(negedge clock);
        id_valid = 1'b0;
        #1;
        chk("wrap_count", 32'(retired_count), 1);

        // Reset during MEM_WAIT abandons the op
        @(negedge clock);
        id = 7'd67;
        id_valid = 1'b1;
        @(negedge clock);
        id_valid = 1'b0;
        #1;
        chk("memrst_stall_pre", 32'(stall), 1);
        reset = 1'b0;
        #1;
        chk("memrst_stall", 32'(stall), 0);
        chk("memrst_en", 32'(enable), 0);
        chk("memrst_count", 32'(retired_count), 0);
        @(negedge clock);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (enable) n++;
            @(negedge clock);
        end
        chk("memrst_nocommit", 32'(n), 0);
        chk("memrst_count_after", 32'(retired_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
